light_phase_timer: RTL and testbench

Upstream pacing stage for the cyclic traffic-light Moore machine. It tracks the RED/GREEN/YELLOW phase and counts a programmable dwell per phase. It emits a one-cycle `advance` pulse when the light FSM must step, and shortens GREEN on a latched pedestrian request. The phase encoding matches the light FSM: 0 = RED, 1 = GREEN, 2 = YELLOW.

---
 rtl/light_phase_timer_if.sv | 30 +++
 rtl/light_phase_timer.sv | 115 +++++++++++
 tb/tb_light_phase_timer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/light_phase_timer_if.sv
// Signal bundle between the traffic-light phase timer and its neighbours.
// The master drives the count enable and pedestrian request; the slave (the timer) returns phase status.
interface light_phase_timer_if #(
  parameter int CNT_W = 4
) ();
  logic             enable;
  logic             ped_req;
  logic             advance;
  logic [1:0]       phase;
  logic [CNT_W-1:0] remaining;
  logic             ped_ack;

  modport master (
    output enable,
    output ped_req,
    input  advance,
    input  phase,
    input  remaining,
    input  ped_ack
  );

  modport slave (
    input  enable,
    input  ped_req,
    output advance,
    output phase,
    output remaining,
    output ped_ack
  );
endinterface

// File: rtl/light_phase_timer.sv
// Phase pacing for the RED/GREEN/YELLOW light FSM.
// Counts a per-phase dwell, strobes advance on the last cycle, and shortens GREEN after a pedestrian request.
module light_phase_timer #(
  parameter int RED_TICKS    = 8,
  parameter int GREEN_TICKS  = 6,
  parameter int YELLOW_TICKS = 2,
  parameter int CNT_W        = 4
) (
  input  logic                clock,
  input  logic                reset,
  light_phase_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    PH_RED    = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_BAD    = 2'd3
  } phase_e;

  localparam logic [CNT_W-1:0] RED_LOAD    = CNT_W'(RED_TICKS - 1);
  localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1'b1);

  // Each dwell must be at least one cycle and TICKS-1 must fit the counter.
  if (RED_TICKS < 1 || RED_TICKS > (1 << CNT_W)) begin : g_bad_red
    $error("light_phase_timer: RED_TICKS out of range for CNT_W");
  end
  if (GREEN_TICKS < 1 || GREEN_TICKS > (1 << CNT_W)) begin : g_bad_green
    $error("light_phase_timer: GREEN_TICKS out of range for CNT_W");
  end
  if (YELLOW_TICKS < 1 || YELLOW_TICKS > (1 << CNT_W)) begin : g_bad_yellow
    $error("light_phase_timer: YELLOW_TICKS out of range for CNT_W");
  end

  phase_e           phase_r;
  phase_e           phase_nx_s;
  logic [CNT_W-1:0] rem_r;
  logic [CNT_W-1:0] rem_nx_s;
  logic             pend_r;
  logic             pend_nx_s;
  logic             ack_r;
  logic             ack_nx_s;

  // Next phase/count, pedestrian latch and acknowledge strobe.
  always_comb begin
    phase_nx_s = phase_r;
    rem_nx_s   = rem_r;
    pend_nx_s  = pend_r | bus.ped_req;
    ack_nx_s   = 1'b0;
    if (bus.enable) begin
      case (phase_r)
        PH_RED: begin
          if (rem_r == CNT_ZERO) begin
            phase_nx_s = PH_GREEN;
            rem_nx_s   = GREEN_LOAD;
          end else begin
            rem_nx_s = rem_r - CNT_ONE;
          end
        end
        PH_GREEN: begin
          if (rem_r == CNT_ZERO) begin
            phase_nx_s = PH_YELLOW;
            rem_nx_s   = YELLOW_LOAD;
          end else if (pend_r && (rem_r > CNT_ONE)) begin
            rem_nx_s = CNT_ONE;
          end else begin
            rem_nx_s = rem_r - CNT_ONE;
          end
        end
        PH_YELLOW: begin
          if (rem_r == CNT_ZERO) begin
            phase_nx_s = PH_RED;
            rem_nx_s   = RED_LOAD;
            ack_nx_s   = pend_r;
            // A request on the serving edge itself starts a new pending request.
            pend_nx_s  = bus.ped_req;
          end else begin
            rem_nx_s = rem_r - CNT_ONE;
          end
        end
        default: begin
          phase_nx_s = PH_RED;
          rem_nx_s   = RED_LOAD;
        end
      endcase
    end else begin
      phase_nx_s = phase_r;
      rem_nx_s   = rem_r;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_r <= PH_RED;
      rem_r   <= RED_LOAD;
      pend_r  <= 1'b0;
      ack_r   <= 1'b0;
    end else begin
      phase_r <= phase_nx_s;
      rem_r   <= rem_nx_s;
      pend_r  <= pend_nx_s;
      ack_r   <= ack_nx_s;
    end
  end

  assign bus.phase     = phase_r;
  assign bus.remaining = rem_r;
  assign bus.ped_ack   = ack_r;
  assign bus.advance   = bus.enable & (rem_r == CNT_ZERO) & (phase_r != PH_BAD);

endmodule

// File: tb/tb_light_phase_timer.sv
// Directed plus randomized bench for light_phase_timer against a dwell-length reference model.
module tb_light_phase_timer;

  localparam int CNT_W = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;

  light_phase_timer_if #(.CNT_W(CNT_W)) bus ();

  light_phase_timer #(
    .RED_TICKS    (8),
    .GREEN_TICKS  (6),
    .YELLOW_TICKS (2),
    .CNT_W        (CNT_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int ticks [3] = '{8, 6, 2};

  // Reference model: phase index, cycles spent in it and its (possibly shortened) length.
  int m_phase;
  int m_spent;
  int m_len;
  bit m_pend;
  bit m_ack;
  bit m_valid = 1'b0;

  int compared   = 0;
  int mismatched = 0;
  int adv_seen   = 0;
  int ack_seen   = 0;

  function automatic int m_rem();
    return m_len - 1 - m_spent;
  endfunction

  function automatic void model_edge(input bit en, input bit req, input bit rst);
    bit nxt_pend;
    bit nxt_ack;
    if (rst) begin
      m_phase = 0;
      m_spent = 0;
      m_len   = ticks[0];
      m_pend  = 1'b0;
      m_ack   = 1'b0;
      m_valid = 1'b1;
    end else begin
      nxt_pend = m_pend | req;
      nxt_ack  = 1'b0;
      if (en) begin
        if (m_rem() == 0) begin
          if (m_phase == 2) begin
            nxt_ack  = m_pend;
            nxt_pend = req;
          end
          m_phase = (m_phase + 1) % 3;
          m_spent = 0;
          m_len   = ticks[m_phase];
        end else begin
          // A pending request cuts GREEN so exactly one cycle remains after this one.
          if (m_phase == 1 && m_pend && m_rem() > 1) m_len = m_spent + 3;
          m_spent = m_spent + 1;
        end
      end
      m_pend = nxt_pend;
      m_ack  = nxt_ack;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit en, input bit req, input bit rst);
    @(negedge clock);
    bus.enable  = en;
    bus.ped_req = req;
    reset       = rst;
    #1;
    if (m_valid) begin
      check("phase", 32'(bus.phase), 32'(m_phase));
      check("remaining", 32'(bus.remaining), 32'(m_rem()));
      check("ped_ack", 32'(bus.ped_ack), 32'(m_ack));
      check("advance", 32'(bus.advance), 32'(en && (m_rem() == 0)));
    end
    if (bus.advance === 1'b1) adv_seen++;
    if (bus.ped_ack === 1'b1) ack_seen++;
    @(posedge clock);
    model_edge(en, req, rst);
  endtask

  task automatic run_until(input int ph, input int rem);
    int n = 0;
    while (!(m_phase == ph && m_rem() == rem) && n < 64) begin
      step(1'b1, 1'b0, 1'b0);
      n++;
    end
    check("reach_state", 32'(n < 64), 32'd1);
  endtask

  initial begin
    bus.enable  = 1'b0;
    bus.ped_req = 1'b0;
    reset       = 1'b1;

    // Reset and free-run.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    #1;
    check("reset_phase", 32'(bus.phase), 32'd0);
    check("reset_remaining", 32'(bus.remaining), 32'd7);
    check("reset_ped_ack", 32'(bus.ped_ack), 32'd0);
    adv_seen = 0;
    ack_seen = 0;
    repeat (32) step(1'b1, 1'b0, 1'b0);
    check("free_advance_count", 32'(adv_seen), 32'd6);
    check("free_ack_count", 32'(ack_seen), 32'd0);

    // Pedestrian truncation at GREEN remaining 4.
    run_until(1, 4);
    ack_seen = 0;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    #1;
    check("trunc_loaded_one", 32'(bus.remaining), 32'd1);
    run_until(0, 5);
    check("trunc_ack_count", 32'(ack_seen), 32'd1);

    // Late request at GREEN remaining 1.
    run_until(1, 1);
    ack_seen = 0;
    step(1'b1, 1'b1, 1'b0);
    run_until(0, 5);
    check("late_ack_count", 32'(ack_seen), 32'd1);

    // Request during RED shortens the following GREEN.
    run_until(0, 5);
    step(1'b1, 1'b1, 1'b0);
    run_until(1, 5);
    step(1'b1, 1'b0, 1'b0);
    #1;
    check("red_req_green_cut", 32'(bus.remaining), 32'd1);
    run_until(0, 6);

    // Enable gating with a request during the freeze.
    run_until(1, 3);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    #1;
    check("freeze_remaining", 32'(bus.remaining), 32'd3);
    check("freeze_phase", 32'(bus.phase), 32'd1);
    repeat (20) step(1'b1, 1'b0, 1'b0);

    // Reset mid-YELLOW with a request pending.
    run_until(1, 5);
    step(1'b1, 1'b1, 1'b0);
    run_until(2, 1);
    step(1'b1, 1'b0, 1'b1);
    #1;
    check("midreset_phase", 32'(bus.phase), 32'd0);
    check("midreset_remaining", 32'(bus.remaining), 32'd7);
    check("midreset_ped_ack", 32'(bus.ped_ack), 32'd0);

    // Request on the YELLOW->RED edge while one is already pending.
    run_until(0, 3);
    step(1'b1, 1'b1, 1'b0);
    run_until(2, 0);
    step(1'b1, 1'b1, 1'b0);
    #1;
    check("simul_ped_ack", 32'(bus.ped_ack), 32'd1);
    run_until(1, 5);
    step(1'b1, 1'b0, 1'b0);
    #1;
    check("simul_still_pending", 32'(bus.remaining), 32'd1);

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
